fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS core, directly upstream of the control unit.
- Holds the PC and a word-addressed instruction memory, and registers the fetched word into an IF/ID register.
- The control unit decodes if_id_instr[31:26] as its opcode. The datapath uses if_id_pc4 for branch and jump target arithmetic.
- Supports stall (hazard hold), redirect (taken beq / j, with flush) and a back-door program-load port for benches.

---
 rtl/fetch_stage.sv | 60 ++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// back-door load port, and the IF/ID pipeline register with stall/redirect control.
module fetch_stage #(
  parameter int unsigned IMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count
);

  localparam int unsigned DEPTH = 2 ** IMEM_AW;

  logic [31:0] imem [DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;

  // Upper PC bits are dropped by the index slice, so fetches alias modulo DEPTH.
  assign fetch_word = imem[pc[IMEM_AW+1:2]];
  assign pc_plus4   = pc + 32'd4;

  // Memory is never reset and is written regardless of pipeline control.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc & 32'hFFFF_FFFC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_plus4;
      if_id_instr <= fetch_word;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the fetch/stall/redirect/wrap
// scenarios, then randomized traffic checked against a behavioural model.
module tb_fetch_stage;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, stall, redirect, imem_we;
  logic [31:0]   redirect_pc, imem_wdata;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   pc, if_id_instr, if_id_pc4, fetch_count;
  logic          if_id_valid;

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] mmem [DEPTH];
  logic [31:0] mpc, minstr, mpc4, mcount;
  logic        mvalid;

  fetch_stage #(.IMEM_AW(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redirect;
    logic [31:0] rpc;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_count;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs; advance the model from the specification's rules.
  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic w, input logic [5:0] wa, input logic [31:0] wd);
    logic [31:0] fetched;
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    imem_we = w; imem_waddr = wa; imem_wdata = wd;
    fetched = mmem[(mpc / 4) % DEPTH];
    if (r) begin
      mpc = 32'h0; minstr = 0; mpc4 = 0; mvalid = 0; mcount = 0;
    end else if (rd) begin
      mpc = (rp / 4) * 4; minstr = 0; mpc4 = 0; mvalid = 0;
    end else if (!s) begin
      minstr = fetched; mpc4 = mpc + 4; mpc = mpc + 4; mvalid = 1; mcount = mcount + 1;
    end
    if (w) mmem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    pc,          mpc);
    chk({tag, ".instr"}, if_id_instr, minstr);
    chk({tag, ".pc4"},   if_id_pc4,   mpc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, mvalid});
    chk({tag, ".count"}, fetch_count, mcount);
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                              input logic w, input logic [5:0] wa, input logic [31:0] wd,
                              input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] e4,
                              input logic ev, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.rpc = rp; v.we = w; v.waddr = wa; v.wdata = wd;
    v.e_pc = ep; v.e_instr = ei; v.e_pc4 = e4; v.e_valid = ev; v.e_count = ec;
    return v;
  endfunction

  function automatic logic [31:0] initword(input int unsigned i);
    case (i)
      0: return 32'h8C01_0004;
      1: return 32'hAC01_0008;
      2: return 32'h1000_0002;
      3: return 32'h0800_0000;
      default: return 32'hA000_0000 + 32'(i);
    endcase
  endfunction

  initial begin
    mpc = 0; minstr = 0; mpc4 = 0; mvalid = 0; mcount = 0;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_we = 0; imem_waddr = 0; imem_wdata = 0;

    // Preload the whole memory while reset is held.
    for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 6'(i), initword(i));
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    chk("reset.pc", pc, 32'h0);
    chk("reset.instr", if_id_instr, 32'h0);
    chk("reset.pc4", if_id_pc4, 32'h0);
    chk("reset.valid", {31'b0, if_id_valid}, 32'h0);
    chk("reset.count", fetch_count, 32'h0);

    //            rst stl rd  rpc           we wa  wdata          pc            instr          pc4           v  count
    vt[0]  = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h4,        32'h8C010004,  32'h4,        1, 1);
    vt[1]  = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h8,        32'hAC010008,  32'h8,        1, 2);
    vt[2]  = mk(0, 1, 0, 32'h0,        0, 0, 0,             32'h8,        32'hAC010008,  32'h8,        1, 2);
    vt[3]  = mk(0, 1, 0, 32'h0,        0, 0, 0,             32'h8,        32'hAC010008,  32'h8,        1, 2);
    vt[4]  = mk(0, 1, 0, 32'h0,        0, 0, 0,             32'h8,        32'hAC010008,  32'h8,        1, 2);
    vt[5]  = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'hC,        32'h10000002,  32'hC,        1, 3);
    vt[6]  = mk(0, 0, 1, 32'h20,       0, 0, 0,             32'h20,       32'h0,         32'h0,        0, 3);
    vt[7]  = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h24,       32'hA0000008,  32'h24,       1, 4);
    vt[8]  = mk(0, 1, 1, 32'h13,       0, 0, 0,             32'h10,       32'h0,         32'h0,        0, 4);
    vt[9]  = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h14,       32'hA0000004,  32'h14,       1, 5);
    vt[10] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0,             32'hFFFFFFFC, 32'h0,         32'h0,        0, 5);
    vt[11] = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h0,        32'hA000003F,  32'h0,        1, 6);
    vt[12] = mk(0, 0, 1, 32'h100,      0, 0, 0,             32'h100,      32'h0,         32'h0,        0, 6);
    vt[13] = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h104,      32'h8C010004,  32'h104,      1, 7);
    vt[14] = mk(0, 0, 0, 32'h0,        1, 1, 32'h20020005,  32'h108,      32'hAC010008,  32'h108,      1, 8);
    vt[15] = mk(0, 0, 1, 32'h4,        0, 0, 0,             32'h4,        32'h0,         32'h0,        0, 8);
    vt[16] = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h8,        32'h20020005,  32'h8,        1, 9);
    vt[17] = mk(1, 1, 1, 32'h40,       0, 0, 0,             32'h0,        32'h0,         32'h0,        0, 0);
    vt[18] = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h4,        32'h8C010004,  32'h4,        1, 1);
    vt[19] = mk(0, 0, 0, 32'h0,        0, 0, 0,             32'h8,        32'h20020005,  32'h8,        1, 2);

    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].rst, vt[i].stall, vt[i].redirect, vt[i].rpc, vt[i].we, vt[i].waddr, vt[i].wdata);
      chk($sformatf("vec%0d.pc", i),    pc,          vt[i].e_pc);
      chk($sformatf("vec%0d.instr", i), if_id_instr, vt[i].e_instr);
      chk($sformatf("vec%0d.pc4", i),   if_id_pc4,   vt[i].e_pc4);
      chk($sformatf("vec%0d.valid", i), {31'b0, if_id_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("vec%0d.count", i), fetch_count, vt[i].e_count);
    end

    // Hand sequence: redirect penalty is one bubble, target arrives on the second edge.
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0032, 1'b0, 6'd0, 32'h0);
    chk_model("seq_redir1");
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    chk("seq_redir2.instr", if_id_instr, 32'hA000_000C);
    chk("seq_redir2.pc4", if_id_pc4, 32'h34);
    chk_model("seq_redir2");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic r, s, rd, w;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 20);
      rd = ($urandom_range(0, 99) < 15);
      w  = ($urandom_range(0, 99) < 25);
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(r, s, rd, rp, w, 6'($urandom_range(0, DEPTH - 1)), $urandom);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
